tone_divider: RTL and testbench

//  Programmable tone generator downstream of the note decoder in the music-player lab.

---
 rtl/tone_if.sv | 19 +
 rtl/tone_divider.sv | 114 +++++++++++
 tb/tb_tone_divider.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tone_if.sv
// Tone divider bus: note preset in, speaker drive and status out.
// SPK_MUTE_EN adds the MUTE input.
interface tone_if #(
  parameter int CNT_W = 11
);
  logic [CNT_W-1:0] TO;
  logic             SPKOUT;
  logic             FULL;
  logic             BUSY;
`ifdef SPK_MUTE_EN
  logic             MUTE;

  modport master (output TO, MUTE, input SPKOUT, FULL, BUSY);
  modport slave  (input TO, MUTE, output SPKOUT, FULL, BUSY);
`else
  modport master (output TO, input SPKOUT, FULL, BUSY);
  modport slave  (input TO, output SPKOUT, FULL, BUSY);
`endif
endinterface

// File: rtl/tone_divider.sv
// Programmable tone divider: a prescaled tick advances an up-counter that
// reloads from TO at each wrap and toggles the speaker output there.
// TO == REST_CODE means silence. A new preset only takes effect at a wrap.
// Optional feature macro: SPK_MUTE_EN (adds MUTE, which gates SPKOUT only).
module tone_divider #(
  parameter int               PRE_DIV   = 12,
  parameter int               CNT_W     = 11,
  parameter logic [CNT_W-1:0] REST_CODE = 11'h7FF
) (
  input logic CLK,
  input logic RST_N,
  tone_if.slave bus
);
  localparam int               PW       = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRE_DIV - 1);
  localparam logic [CNT_W-1:0] ONES     = '1;

  typedef enum logic {REST, TONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgl_q, tgl_d;
  logic             full_q, full_d;
  logic             busy_q, busy_d;

  // With PRE_DIV == 1 pre_cnt stays at 0 and tick is high every cycle.
  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler: counts 0..PRE_DIV-1, tick on the last count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  // Next-state: load on leaving REST, count up, reload or stop at wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgl_d   = tgl_q;
    full_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      REST: begin
        cnt_d  = ONES;
        tgl_d  = 1'b0;
        busy_d = 1'b0;
        if (tick && bus.TO != REST_CODE) begin
          state_d = TONE;
          cnt_d   = bus.TO;
          busy_d  = 1'b1;
        end
      end
      TONE: begin
        if (tick) begin
          if (cnt_q != ONES) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Wrap: TO is sampled right here, so a preset change lands on
            // a period boundary and never shortens a half-period.
            full_d = 1'b1;
            if (bus.TO == REST_CODE) begin
              state_d = REST;
              cnt_d   = ONES;
              busy_d  = 1'b0;
              tgl_d   = 1'b0;
            end else begin
              cnt_d = bus.TO;
              tgl_d = ~tgl_q;
            end
          end
        end
      end
      default: state_d = REST;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= REST;
      cnt_q   <= ONES;
      tgl_q   <= 1'b0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgl_q   <= tgl_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.FULL = full_q;
  assign bus.BUSY = busy_q;

`ifdef SPK_MUTE_EN
  logic spk_q;

  // Mute gates only the pin; registering the next toggle value keeps the
  // unmuted pin identical to the internal toggle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) spk_q <= 1'b0;
    else        spk_q <= bus.MUTE ? 1'b0 : tgl_d;
  end

  assign bus.SPKOUT = spk_q;
`else
  assign bus.SPKOUT = tgl_q;
`endif
endmodule

// File: tb/tb_tone_divider.sv
// Bench for tone_divider: two instances (PRE_DIV=1 and PRE_DIV=12) checked
// every cycle against a tick-countdown model, plus directed interval checks.
module tb_tone_divider;
  logic clk;
  logic rst_n;
  int   tot = 0;
  int   bad = 0;

  tone_if #(.CNT_W(11)) b1();
  tone_if #(.CNT_W(11)) b12();

  tone_divider #(.PRE_DIV(1),  .CNT_W(11), .REST_CODE(11'h7FF)) dut1  (.CLK(clk), .RST_N(rst_n), .bus(b1));
  tone_divider #(.PRE_DIV(12), .CNT_W(11), .REST_CODE(11'h7FF)) dut12 (.CLK(clk), .RST_N(rst_n), .bus(b12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a sounding flag, ticks left until the next wrap, and the phase.
  typedef struct {
    bit snd;
    int rem;
    bit ph;
    bit spk;
    bit full;
    int cyc;
  } mdl_t;

  mdl_t m1, m12;
  logic mute1, mute12;

`ifdef SPK_MUTE_EN
  assign mute1  = b1.MUTE;
  assign mute12 = b12.MUTE;
`else
  assign mute1  = 1'b0;
  assign mute12 = 1'b0;
`endif

  function automatic mdl_t mreset();
    mdl_t r;
    r.snd = 0; r.rem = 0; r.ph = 0; r.spk = 0; r.full = 0; r.cyc = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, int p, logic [10:0] to, logic mute);
    mdl_t r;
    r      = m;
    r.full = 0;
    r.cyc  = m.cyc + 1;
    if ((m.cyc % p) == p - 1) begin
      if (!m.snd) begin
        if (to != 11'h7FF) begin
          r.snd = 1;
          r.rem = 2048 - int'(to);
        end
      end else begin
        r.rem = m.rem - 1;
        if (r.rem == 0) begin
          r.full = 1;
          if (to == 11'h7FF) begin
            r.snd = 0;
            r.ph  = 0;
          end else begin
            r.rem = 2048 - int'(to);
            r.ph  = ~m.ph;
          end
        end
      end
    end
    r.spk = r.ph & ~mute;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1  <= mreset();
      m12 <= mreset();
    end else begin
      m1  <= step(m1,  1,  b1.TO,  mute1);
      m12 <= step(m12, 12, b12.TO, mute12);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("spk1",   32'(b1.SPKOUT),  32'(m1.spk));
    chk("full1",  32'(b1.FULL),    32'(m1.full));
    chk("busy1",  32'(b1.BUSY),    32'(m1.snd));
    chk("spk12",  32'(b12.SPKOUT), 32'(m12.spk));
    chk("full12", 32'(b12.FULL),   32'(m12.full));
    chk("busy12", 32'(b12.BUSY),   32'(m12.snd));
  endtask

  // Cycles until the selected instance shows FULL; a miss is a failure.
  task automatic wait_full(input int sel, input int budget, output int n);
    logic f;
    n = 0;
    do begin
      cycle();
      n++;
      f = (sel == 1) ? b1.FULL : b12.FULL;
    end while (f !== 1'b1 && n < budget);
    chk("full_seen", 32'(f), 32'd1);
  endtask

  initial begin
    int n, n2, nf;
    rst_n   = 1'b0;
    b1.TO   = 11'h7FF;
    b12.TO  = 11'h7FF;
`ifdef SPK_MUTE_EN
    b1.MUTE  = 1'b0;
    b12.MUTE = 1'b0;
`endif
    #3;
    chk("rst_spk",  32'(b1.SPKOUT), 0);
    chk("rst_full", 32'(b1.FULL),   0);
    chk("rst_busy", 32'(b1.BUSY),   0);
    chk("rst_busy12", 32'(b12.BUSY), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();

    // Start a tone: BUSY on the first tick, FULL every 4, SPKOUT period 8.
    b1.TO = 11'h7FC;
    cycle();
    chk("busy_first_tick", 32'(b1.BUSY), 1);
    wait_full(1, 100, n);
    chk("first_full_7fc", n, 4);
    wait_full(1, 100, n);
    chk("full_int_7fc", n, 4);
    nf = b1.SPKOUT;
    wait_full(1, 100, n);
    wait_full(1, 100, n2);
    chk("spk_period_7fc", n + n2, 8);
    chk("spk_phase_back", 32'(b1.SPKOUT), 32'(nf));

    // Preset change one cycle after FULL takes effect after the next wrap.
    cycle();
    b1.TO = 11'h7FE;
    wait_full(1, 100, n);
    chk("full_int_hold", n + 1, 4);
    wait_full(1, 100, n);
    chk("full_int_7fe", n, 2);

    // Rest code: silence at the next wrap, then no more FULL pulses.
    b1.TO = 11'h7FF;
    wait_full(1, 100, n);
    chk("rest_busy", 32'(b1.BUSY),   0);
    chk("rest_spk",  32'(b1.SPKOUT), 0);
    nf = 0;
    repeat (20) begin
      cycle();
      if (b1.FULL === 1'b1) nf++;
    end
    chk("rest_no_full", nf, 0);
    b1.TO = 11'h7FD;
    wait_full(1, 100, n);
    chk("first_full_7fd", n, 4);
    wait_full(1, 100, n);
    chk("full_int_7fd", n, 3);

`ifdef SPK_MUTE_EN
    // Mute gates the pin only; counting and FULL carry on.
    b1.MUTE = 1'b1;
    cycle();
    chk("mute_spk", 32'(b1.SPKOUT), 0);
    wait_full(1, 100, n);
    wait_full(1, 100, n);
    chk("mute_full_int", n, 3);
    chk("mute_busy", 32'(b1.BUSY), 1);
    b1.MUTE = 1'b0;
    cycle();
    chk("unmute_phase", 32'(b1.SPKOUT), 32'(m1.ph));
`endif

    // Asynchronous reset mid-tone, checked between clock edges.
    wait_full(1, 100, n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_spk",  32'(b1.SPKOUT), 0);
    chk("async_rst_full", 32'(b1.FULL),   0);
    chk("async_rst_busy", 32'(b1.BUSY),   0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_full(1, 100, n);
    chk("restart_first_full", n, 4);

    // Random presets, rests and mutes against the model.
    repeat (600) begin
      if ($urandom_range(0, 7) == 0)
        b1.TO = ($urandom_range(0, 3) == 0) ? 11'h7FF : 11'(11'h7F0 + $urandom_range(0, 14));
`ifdef SPK_MUTE_EN
      if ($urandom_range(0, 15) == 0) b1.MUTE = ~b1.MUTE;
`endif
      cycle();
    end
`ifdef SPK_MUTE_EN
    b1.MUTE = 1'b0;
`endif
    b1.TO = 11'h7FF;

    // Prescaled 392 Hz tone: FULL every 15300 CLK, SPKOUT period 30600.
    b12.TO = 11'h305;
    wait_full(2, 20000, n);
    chk("spk12_first_rise", 32'(b12.SPKOUT), 1);
    wait_full(2, 16000, n);
    chk("full12_int", n, 15300);
    chk("spk12_fall", 32'(b12.SPKOUT), 0);
    wait_full(2, 16000, n2);
    chk("full12_int2", n2, 15300);
    chk("spk12_period", n + n2, 30600);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
